// File: rtl/scpu_pkg.sv
// Shared scpu pipeline definitions: hazard FSM encoding and common constants.
package scpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    SHADOW   = 2'd2
  } hz_state_t;

  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  // Shadow counter holds up to 7 post-redirect squash cycles.
  localparam int unsigned SHADOW_W = 3;

endpackage

// File: rtl/hz_perf_cnt.sv
// Free-running enable counter for hazard performance statistics; wraps silently.
module hz_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count every enabled cycle, modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage scpu pipeline: memory freeze,
// EX-resolved redirects with fetch shadow squashing, and load-use interlock.
module pipe_hazard_ctrl
  import scpu_pkg::*;
#(
  parameter int unsigned SHADOW_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT   = 255,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // Wait counter only needs to reach MEM_TIMEOUT-1 before the timeout fires.
  localparam int unsigned TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  hz_state_t           state;
  logic [SHADOW_W-1:0] shadow_cnt;
  logic [TO_W-1:0]     wait_cnt;

  logic mem_busy;
  logic wait_hit;
  logic freeze;
  logic timeout;
  logic redirect_fire;
  logic load_use;

  // Hazard decode shared by the output logic and the state register.
  assign mem_busy      = mem_req && !mem_ready;
  assign wait_hit      = (wait_cnt == TO_W'(MEM_TIMEOUT - 1));
  assign freeze        = mem_busy && !wait_hit;
  assign timeout       = mem_busy && wait_hit;
  assign redirect_fire = ex_branch_taken && !freeze;
  assign load_use      = ex_mem_read && (ex_rd_addr != REG_ZERO) &&
                         ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                          (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

  // Pipeline controls in priority order: freeze, redirect, shadow, load-use.
  always_comb begin
    pc_stall       = 1'b0;
    ifid_stall     = 1'b0;
    ifid_flush     = 1'b0;
    idex_stall     = 1'b0;
    idex_flush     = 1'b0;
    exmem_stall    = 1'b0;
    memwb_flush    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_err        = 1'b0;
    if (!rst) begin
      if (freeze) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end else begin
        mem_err = timeout;
        if (redirect_fire) begin
          redirect_valid = 1'b1;
          redirect_pc    = ex_branch_target;
          ifid_flush     = 1'b1;
          idex_flush     = 1'b1;
        end else if (state == SHADOW) begin
          // IF/ID already holds a squashed fetch, so load-use cannot apply.
          ifid_flush = 1'b1;
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
      end
    end
  end

  // FSM state with shadow and memory-wait counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      shadow_cnt <= '0;
      wait_cnt   <= '0;
    end else if (freeze) begin
      state    <= MEM_WAIT;
      wait_cnt <= wait_cnt + TO_W'(1);
    end else begin
      wait_cnt <= '0;
      if (redirect_fire) begin
        if (SHADOW_CYCLES > 0) begin
          state      <= SHADOW;
          shadow_cnt <= SHADOW_W'(SHADOW_CYCLES);
        end else begin
          state <= RUN;
        end
      end else if (state == SHADOW) begin
        shadow_cnt <= shadow_cnt - SHADOW_W'(1);
        if (shadow_cnt <= SHADOW_W'(1)) begin
          state <= RUN;
        end
      end else begin
        state <= RUN;
      end
    end
  end

  hz_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (pc_stall),
    .count (stall_cycles)
  );

  hz_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (redirect_valid),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected controls are queued as each
// cycle's stimulus is applied and compared once the outputs settle.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 32;

  // Control vector bit order:
  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
  //  exmem_stall, memwb_flush, redirect_valid, mem_err}
  localparam logic [8:0] C_NONE  = 9'h000;
  localparam logic [8:0] C_LU    = 9'h190;
  localparam logic [8:0] C_REDIR = 9'h052;
  localparam logic [8:0] C_SHAD  = 9'h040;
  localparam logic [8:0] C_FRZ   = 9'h1AC;
  localparam logic [8:0] C_ERR   = 9'h001;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd_addr;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic [31:0]      ex_branch_target;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_stall;
  logic             idex_flush;
  logic             exmem_stall;
  logic             memwb_flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  logic [8:0] got_ctl;
  assign got_ctl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                    exmem_stall, memwb_flush, redirect_valid, mem_err};

  int n_cmp = 0;
  int n_err = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  logic [40:0] exp_q[$];
  string       tag_q[$];

  pipe_hazard_ctrl #(
    .SHADOW_CYCLES (1),
    .MEM_TIMEOUT   (4),
    .CNT_W         (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1_addr      (id_rs1_addr),
    .id_rs2_addr      (id_rs2_addr),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .ex_rd_addr       (ex_rd_addr),
    .ex_mem_read      (ex_mem_read),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .pc_stall         (pc_stall),
    .ifid_stall       (ifid_stall),
    .ifid_flush       (ifid_flush),
    .idex_stall       (idex_stall),
    .idex_flush       (idex_flush),
    .exmem_stall      (exmem_stall),
    .memwb_flush      (memwb_flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .mem_err          (mem_err),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1_addr      = 5'd0;
    id_rs2_addr      = 5'd0;
    id_uses_rs1      = 1'b0;
    id_uses_rs2      = 1'b0;
    ex_rd_addr       = 5'd0;
    ex_mem_read      = 1'b0;
    ex_branch_taken  = 1'b0;
    ex_branch_target = 32'h0;
    mem_req          = 1'b0;
    mem_ready        = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
    ex_mem_read = 1'b1;
    ex_rd_addr  = rd;
    id_rs1_addr = rs1;
    id_uses_rs1 = u1;
    id_rs2_addr = rs2;
    id_uses_rs2 = u2;
  endtask

  // One pipeline cycle: queue the expectation, sample before the rising edge,
  // then step to the next falling edge where the following stimulus is applied.
  task automatic cyc(input string tag, input logic [8:0] ectl, input logic [31:0] epc);
    logic [40:0] e;
    string       t;
    exp_q.push_back({ectl, epc});
    tag_q.push_back(tag);
    if (ectl[8]) exp_stall++;
    if (ectl[1]) exp_flush++;
    #2;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, "/ctl"}, 64'(got_ctl), 64'(e[40:32]));
    check({t, "/pc"}, 64'(redirect_pc), 64'(e[31:0]));
    @(negedge clk);
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "/stall_cycles"}, 64'(stall_cycles), 64'(exp_stall));
    check({tag, "/flush_events"}, 64'(flush_events), 64'(exp_flush));
  endtask

  // Reset with busy inputs; controls and counters must read zero regardless.
  task automatic do_reset();
    rst              = 1'b1;
    exp_stall        = 0;
    exp_flush        = 0;
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'hDEAD_BEEF;
    mem_req          = 1'b1;
    mem_ready        = 1'b0;
    #1;
    check("reset/ctl", 64'(got_ctl), 64'(C_NONE));
    check("reset/pc", 64'(redirect_pc), 64'h0);
    check_cnt("reset");
    @(negedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    do_reset();

    // Load-use on rs1, then the load moves on and the stall clears.
    set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    cyc("lu_rs1", C_LU, 32'h0);
    idle();
    cyc("lu_clear", C_NONE, 32'h0);
    check_cnt("lu");

    // Load-use on rs2 and a match on an unused operand.
    set_load_use(5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
    cyc("lu_rs2", C_LU, 32'h0);
    set_load_use(5'd9, 5'd9, 1'b0, 5'd9, 1'b0);
    cyc("lu_unused", C_NONE, 32'h0);

    // Load to x0 never stalls.
    set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    cyc("lu_x0", C_NONE, 32'h0);
    idle();
    check_cnt("lu_done");

    // Taken branch with one shadow cycle.
    do_reset();
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'h0000_0040;
    cyc("br", C_REDIR, 32'h0000_0040);
    idle();
    cyc("br_shadow", C_SHAD, 32'h0);
    cyc("br_run", C_NONE, 32'h0);
    check_cnt("br");

    // Load-use during shadow is ignored, then applies once back in RUN.
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'h0000_0080;
    cyc("br2", C_REDIR, 32'h0000_0080);
    ex_branch_taken = 1'b0;
    set_load_use(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    cyc("shadow_lu", C_SHAD, 32'h0);
    cyc("run_lu", C_LU, 32'h0);
    idle();

    // A second branch in shadow re-arms and redirects again.
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'h0000_0100;
    cyc("br3", C_REDIR, 32'h0000_0100);
    ex_branch_target = 32'h0000_0200;
    cyc("br3_rearm", C_REDIR, 32'h0000_0200);
    idle();
    cyc("br3_shadow", C_SHAD, 32'h0);
    cyc("br3_run", C_NONE, 32'h0);
    check_cnt("br3");

    // Memory wait holding a branch: three frozen cycles, then one redirect.
    do_reset();
    mem_req          = 1'b1;
    mem_ready        = 1'b0;
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'h0000_0400;
    cyc("mw1", C_FRZ, 32'h0);
    cyc("mw2", C_FRZ, 32'h0);
    cyc("mw3", C_FRZ, 32'h0);
    mem_ready = 1'b1;
    cyc("mw_ready", C_REDIR, 32'h0000_0400);
    idle();
    cyc("mw_shadow", C_SHAD, 32'h0);
    cyc("mw_run", C_NONE, 32'h0);
    check_cnt("mw");

    // Freeze outranks load-use; ready memory with no wait never freezes.
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    set_load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    cyc("frz_lu", C_FRZ, 32'h0);
    mem_ready = 1'b1;
    cyc("ready_lu", C_LU, 32'h0);
    idle();
    mem_req   = 1'b1;
    mem_ready = 1'b1;
    cyc("ready_nowait", C_NONE, 32'h0);
    idle();
    check_cnt("frz");

    // Timeout with memory never ready: error on the fourth cycle, twice.
    do_reset();
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      cyc("to_w1", C_FRZ, 32'h0);
      cyc("to_w2", C_FRZ, 32'h0);
      cyc("to_w3", C_FRZ, 32'h0);
      cyc("to_err", C_ERR, 32'h0);
    end
    idle();
    cyc("to_run", C_NONE, 32'h0);
    check_cnt("to");

    // Asynchronous reset in the middle of a shadow cycle.
    do_reset();
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'h0000_0040;
    cyc("rs_br", C_REDIR, 32'h0000_0040);
    idle();
    #1;
    check("rs_pre/ctl", 64'(got_ctl), 64'(C_SHAD));
    check_cnt("rs_pre");
    rst       = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
    #1;
    check("rs_async/ctl", 64'(got_ctl), 64'(C_NONE));
    check_cnt("rs_async");
    @(negedge clk);
    rst = 1'b0;
    cyc("rs_after", C_NONE, 32'h0);
    cyc("rs_after2", C_NONE, 32'h0);
    check_cnt("rs_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage scpu pipeline.
- Consumes register addresses and status from ID, EX and MEM; drives stall and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Issues the PC redirect on a taken branch or jump resolved in EX.
- Contains an FSM for multi-cycle data-memory waits and post-redirect fetch squashing, plus performance counters.

Parameters:
- SHADOW_CYCLES, 1: extra cycles IF/ID flush stays asserted after a redirect, covering in-flight synchronous imem fetches. Range 0..7.
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before mem_err is raised.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1_addr  in  5  ID source register 1
- id_rs2_addr  in  5  ID source register 2
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd_addr  in  5  EX destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- ex_branch_target  in  32  resolved target address
- mem_req  in  1  MEM stage accessing dmem
- mem_ready  in  1  dmem completes this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  load NOP into IF/ID
- idex_stall  out  1  hold ID/EX
- idex_flush  out  1  bubble into ID/EX
- exmem_stall  out  1  hold EX/MEM
- memwb_flush  out  1  bubble into MEM/WB
- redirect_valid  out  1  PC takes redirect_pc this cycle
- redirect_pc  out  32  redirect address
- mem_err  out  1  one-cycle pulse on dmem timeout
- stall_cycles  out  CNT_W  cycles with pc_stall asserted
- flush_events  out  CNT_W  count of redirects

Behaviour:
Reset:
- State RUN; shadow and timeout counters cleared.
- All control outputs 0, redirect_pc 0, both perf counters 0.
- Reset asserted mid-wait or mid-shadow aborts immediately to RUN with counters cleared.

FSM states RUN, MEM_WAIT, SHADOW. Outputs are Moore/Mealy mix, evaluated in this priority order:
1. Memory freeze (highest).
   - Condition: mem_req && !mem_ready, in any state.
   - Action: pc_stall, ifid_stall, idex_stall, exmem_stall = 1; memwb_flush = 1; redirect_valid = 0.
   - Next state MEM_WAIT; the timeout counter increments each cycle.
   - If the counter reaches MEM_TIMEOUT: pulse mem_err, force next state RUN, clear the counter. The pipeline proceeds as if ready.
   - mem_ready in MEM_WAIT: freeze deasserts the same cycle, next state RUN.
2. Redirect.
   - Condition: ex_branch_taken and no freeze.
   - Action: redirect_valid = 1 and redirect_pc = ex_branch_target, both combinational; ifid_flush = 1; idex_flush = 1.
   - flush_events increments by 1.
   - If SHADOW_CYCLES > 0: next state SHADOW with the counter loaded to SHADOW_CYCLES.
   - A branch in EX during a freeze is held by exmem_stall and fires on the first unfrozen cycle, exactly once.
3. SHADOW state.
   - ifid_flush = 1 each cycle; the counter decrements; return to RUN at 0.
   - A new ex_branch_taken in SHADOW re-arms the counter and redirects again.
   - A load-use condition in SHADOW is ignored because IF/ID holds a NOP.
4. Load-use stall (lowest).
   - Condition: ex_mem_read && ex_rd_addr != 0 && ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr)).
   - Action: pc_stall, ifid_stall = 1 and idex_flush = 1 for exactly one cycle.
   - It clears naturally because the load advances to MEM.

Counters:
- stall_cycles increments on every cycle pc_stall = 1.
- Both perf counters wrap modulo 2^CNT_W and are never saturating.

Other rules:
- ifid_flush and ifid_stall are never both 1; flush wins.
- idex_flush and idex_stall are never both 1; stall wins, since freeze dominates.
- x0 writes never cause a stall.

Decomposition:
- Shared package scpu_pkg holds:
  - state encoding hz_state_t (RUN = 0, MEM_WAIT = 1, SHADOW = 2);
  - NOP_INST = 32'h00000013;
  - REG_ZERO = 5'd0.
- Sub-module hz_perf_cnt: a generic CNT_W-bit enable counter with async reset, instantiated twice.
- The hazard comparators stay inline.

Test Plan:
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 → one cycle of pc_stall = ifid_stall = idex_flush = 1; stall_cycles = 1.
- x0 load: same as above with ex_rd = 0 and id_rs1 = 0 → no stall; all controls 0.
- Taken branch, target 0x00000040, SHADOW_CYCLES = 1 → cycle 0: redirect_valid = 1, redirect_pc = 0x40, ifid_flush = idex_flush = 1; cycle 1: ifid_flush only; flush_events = 1.
- Mem wait: mem_req = 1 with mem_ready low for 3 cycles, branch held in EX → 3 cycles of all stalls plus memwb_flush, stall_cycles = 3; redirect fires once on cycle 4.
- Timeout: MEM_TIMEOUT = 4, mem_ready never asserted → mem_err pulses on cycle 4, state RUN on cycle 5.
- Reset mid-SHADOW: assert rst asynchronously → all outputs 0 immediately; after release, no residual ifid_flush.
